wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Architectural state sink for the writeback stage of the 5-stage MIPS32 pipeline.
- Consumes the MEM/WB pipeline register outputs: GPR write (address, enable, data) and HI/LO write (enable, hi, lo).
- Holds the general-purpose register file (two combinational read ports used by the decode stage) and the HI/LO register pair (read by the execute stage for MFHI/MFLO).
- $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, GPR address width.
- NUM_REGS, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- we  in  1  GPR write enable (from wb_wreg).
- waddr  in  ADDR_W  GPR write address (from wb_wd).
- wdata  in  DATA_W  GPR write data (from wb_wdata).
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data, combinational.
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data, combinational.
- whilo  in  1  HI/LO write enable (from wb_whilo).
- hi_i  in  DATA_W  HI write data.
- lo_i  in  DATA_W  LO write data.
- hi_o  out  DATA_W  current HI, combinational.
- lo_o  out  DATA_W  current LO, combinational.

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - On a rising edge with rst=1, all GPRs 1..31, HI and LO are cleared to 0.
  - While rst=1, rdata1, rdata2, hi_o and lo_o are driven to 0 combinationally.
  - Writes presented during reset are discarded.
  - Reset asserted mid-stream overrides any pending write in the same cycle.
- GPR write:
  - On a rising edge with rst=0, we=1 and waddr!=0, the GPR at waddr takes wdata.
  - waddr=0 is ignored; $0 always reads 0.
  - Write latency is one edge.
- GPR read, ports identical and independent. Priority order:
  - rst=1 -> 0
  - re=0 -> 0
  - raddr=0 -> 0
  - bypass condition (see Optional Feature) -> wdata
  - otherwise stored value
- Both ports may read the same address; both return the same value.
- HI/LO:
  - On a rising edge with rst=0 and whilo=1, HI<=hi_i and LO<=lo_i together. A partial update is not possible.
  - whilo=0 holds both registers.
  - hi_o/lo_o follow the priority rst -> 0, bypass condition -> hi_i/lo_i, otherwise stored value.
- GPR and HI/LO writes in the same cycle are independent; both commit.
- No internal state besides storage. Outputs have no registered latency.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Write-to-read forwarding.
  - If rst=0, we=1, waddr!=0, re=1 and raddr==waddr, the port returns wdata in the same cycle as the write.
  - If whilo=1, hi_o/lo_o return hi_i/lo_i in the same cycle.
- Undefined:
  - Reads return only stored values.
  - Data written this cycle is visible after the next rising edge.
  - The hazard unit must insert one extra stall for a WB-to-ID dependency.
- Reset and $0 rules are unchanged in both builds.

Test Plan:
- Reset with all regs preloaded: load $5=0x12345678 and HI=0xAAAA0000, assert rst 1 cycle, deassert -> reading $5 (re1=1) returns 0; hi_o=0.
- Basic write/read: we=1, waddr=7, wdata=0xDEADBEEF, edge; then re1=1, raddr1=7 and re2=1, raddr2=7 -> rdata1=rdata2=0xDEADBEEF. With re2=0 -> rdata2=0.
- $0 protection: we=1, waddr=0, wdata=0xFFFFFFFF, edge; read raddr1=0 with re1=1 -> 0.
- Same-cycle bypass: $3 holds 0x11; drive we=1, waddr=3, wdata=0x22 with re1=1, raddr1=3 before the edge -> rdata1=0x22 with WB_BYPASS_EN, 0x11 without; after the edge both builds read 0x22.
- HI/LO: whilo=1, hi_i=0x1, lo_i=0x2, edge; then whilo=0 with hi_i=0x9 -> hi_o=0x1, lo_o=0x2. A concurrent GPR write to $4=0x44 in the whilo cycle also commits.
- Reset mid-write: rst=1 and we=1, waddr=9, wdata=0x99 on the same edge, then rst=0 -> $9 reads 0.

Source files
------------

// File: rtl/wb_regfile.sv
// MIPS32 writeback-stage register file: 32 GPRs ($0 hardwired to zero), the HI/LO pair, and two combinational read ports.
// Optional `WB_BYPASS_EN: the write data presented in this cycle is forwarded to reads and to hi_o/lo_o in the same cycle.

module wb_regfile_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              rst_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

`ifdef WB_BYPASS_EN
    // The write address is nonzero whenever the read address matches it, because a read of $0 takes the earlier branch.
    always_comb begin
        rdata_o = '0;
        if (rst_i || !re_i || raddr_i == '0)
            rdata_o = '0;
        else if (we_i && waddr_i == raddr_i)
            rdata_o = wdata_i;
        else
            rdata_o = stored_i;
    end
`else
    logic unused_wr;
    assign unused_wr = ^{we_i, waddr_i, wdata_i};

    always_comb begin
        rdata_o = '0;
        if (rst_i || !re_i || raddr_i == '0)
            rdata_o = '0;
        else
            rdata_o = stored_i;
    end
`endif

endmodule

module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int NUM_RD = 2;

    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              gpr_we;

    assign gpr_we = we && (waddr != '0);

    // Entry 0 is cleared by reset and never written, so $0 always holds zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                gpr_q[i] <= '0;
        end else if (gpr_we) begin
            gpr_q[waddr] <= wdata;
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (whilo) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef WB_BYPASS_EN
    assign hi_o = rst ? '0 : (whilo ? hi_i : hi_q);
    assign lo_o = rst ? '0 : (whilo ? lo_i : lo_q);
`else
    assign hi_o = rst ? '0 : hi_q;
    assign lo_o = rst ? '0 : lo_q;
`endif

    logic [NUM_RD-1:0]             rd_en;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_stored;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

    assign rd_en   = {re2, re1};
    assign rd_addr = {raddr2, raddr1};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign rd_stored[p] = gpr_q[rd_addr[p]];

        wb_regfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rdport (
            .rst_i    (rst),
            .re_i     (rd_en[p]),
            .raddr_i  (rd_addr[p]),
            .stored_i (rd_stored[p]),
            .we_i     (we),
            .waddr_i  (waddr),
            .wdata_i  (wdata),
            .rdata_o  (rd_data[p])
        );
    end

    assign rdata1 = rd_data[0];
    assign rdata2 = rd_data[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed literal checks followed by randomized traffic, all compared against a behavioural model.
// The bench follows the build: define WB_BYPASS_EN for both files or for neither.

module tb_wb_regfile;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, re1 = 1'b0, re2 = 1'b0, whilo = 1'b0;
    logic [4:0]  waddr = '0, raddr1 = '0, raddr2 = '0;
    logic [31:0] wdata = '0, hi_i = '0, lo_i = '0;
    logic [31:0] rdata1, rdata2, hi_o, lo_o;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    // Behavioural model: architectural state only.
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo;
    bit          m_vld = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = '0;
            m_hi  = '0;
            m_lo  = '0;
            m_vld = 1'b1;
        end else begin
            if (we && waddr != 0) m_gpr[waddr] = wdata;
            if (whilo) begin
                m_hi = hi_i;
                m_lo = lo_i;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic e, input logic [4:0] a);
        if (rst || !e || a == 0) return 32'h0;
        if (BYP && we && waddr == a) return wdata;
        return m_gpr[a];
    endfunction

    function automatic logic [31:0] exp_hl(input bit is_hi);
        if (rst) return 32'h0;
        if (BYP && whilo) return is_hi ? hi_i : lo_i;
        return is_hi ? m_hi : m_lo;
    endfunction

    // Hand-computed expectations, posted by the driver for the current cycle.
    // Slot 0 = rdata1, 1 = rdata2, 2 = hi_o, 3 = lo_o.
    bit          lit_en  [4];
    logic [31:0] lit_exp [4];
    string       lit_name[4];

    int errors = 0;
    int checks = 0;

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_vld) begin
            cmp("model rdata1", rdata1, exp_rd(re1, raddr1));
            cmp("model rdata2", rdata2, exp_rd(re2, raddr2));
            cmp("model hi_o", hi_o, exp_hl(1'b1));
            cmp("model lo_o", lo_o, exp_hl(1'b0));
        end
        for (int s = 0; s < 4; s++) begin
            if (lit_en[s]) begin
                case (s)
                    0:       cmp(lit_name[s], rdata1, lit_exp[s]);
                    1:       cmp(lit_name[s], rdata2, lit_exp[s]);
                    2:       cmp(lit_name[s], hi_o, lit_exp[s]);
                    default: cmp(lit_name[s], lo_o, lit_exp[s]);
                endcase
            end
        end
    end

    // Advance to just after the next rising edge with every input idle and no literal posted.
    task automatic cyc();
        @(posedge clk);
        #1;
        rst = 0; we = 0; waddr = 0; wdata = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        whilo = 0; hi_i = 0; lo_i = 0;
        for (int s = 0; s < 4; s++) lit_en[s] = 1'b0;
    endtask

    task automatic lit(input int s, input string n, input logic [31:0] e);
        lit_en[s]   = 1'b1;
        lit_name[s] = n;
        lit_exp[s]  = e;
    endtask

    initial begin
        for (int s = 0; s < 4; s++) lit_en[s] = 1'b0;

        // Reset, then preload $5 and HI/LO.
        cyc(); rst = 1; re1 = 1; raddr1 = 5;
        lit(0, "rd during rst", 32'h0); lit(2, "hi during rst", 32'h0);
        cyc(); we = 1; waddr = 5; wdata = 32'h12345678;
        whilo = 1; hi_i = 32'hAAAA0000; lo_i = 32'h00005555;
        cyc(); re1 = 1; raddr1 = 5;
        lit(0, "preload $5", 32'h12345678); lit(2, "preload hi", 32'hAAAA0000);
        cyc(); rst = 1; re1 = 1; raddr1 = 5; whilo = 1; hi_i = 32'h77;
        lit(0, "rst forces rd 0", 32'h0); lit(2, "rst forces hi 0", 32'h0);
        cyc(); re1 = 1; raddr1 = 5;
        lit(0, "$5 cleared", 32'h0); lit(2, "hi cleared", 32'h0); lit(3, "lo cleared", 32'h0);

        // Basic write and dual read.
        cyc(); we = 1; waddr = 7; wdata = 32'hDEADBEEF;
        cyc(); re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
        lit(0, "rd1 $7", 32'hDEADBEEF); lit(1, "rd2 $7", 32'hDEADBEEF);
        cyc(); re1 = 1; raddr1 = 7; re2 = 0; raddr2 = 7;
        lit(0, "rd1 $7 again", 32'hDEADBEEF); lit(1, "rd2 disabled", 32'h0);

        // $0 stays zero, even while it is being written.
        cyc(); we = 1; waddr = 0; wdata = 32'hFFFFFFFF; re1 = 1; raddr1 = 0;
        lit(0, "$0 during write", 32'h0);
        cyc(); re1 = 1; raddr1 = 0;
        lit(0, "$0 after write", 32'h0);

        // Same-cycle forwarding.
        cyc(); we = 1; waddr = 3; wdata = 32'h11;
        cyc(); we = 1; waddr = 3; wdata = 32'h22; re1 = 1; raddr1 = 3;
        lit(0, "bypass $3", BYP ? 32'h22 : 32'h11);
        cyc(); re1 = 1; raddr1 = 3;
        lit(0, "$3 committed", 32'h22);

        // HI/LO together with a concurrent GPR write.
        cyc(); whilo = 1; hi_i = 32'h1; lo_i = 32'h2; we = 1; waddr = 4; wdata = 32'h44;
        lit(2, "hi in write cycle", BYP ? 32'h1 : 32'h0);
        lit(3, "lo in write cycle", BYP ? 32'h2 : 32'h0);
        cyc(); whilo = 0; hi_i = 32'h9; lo_i = 32'h8; re2 = 1; raddr2 = 4;
        lit(2, "hi held", 32'h1); lit(3, "lo held", 32'h2); lit(1, "$4 committed", 32'h44);

        // Reset on the same edge as a write.
        cyc(); rst = 1; we = 1; waddr = 9; wdata = 32'h99;
        cyc(); re1 = 1; raddr1 = 9;
        lit(0, "$9 dropped", 32'h0);

        // Randomized traffic; narrow address ranges make collisions common.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst    = ($urandom_range(0, 59) == 0);
            we     = $urandom_range(0, 1);
            waddr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wdata  = $urandom;
            re1    = ($urandom_range(0, 3) != 0);
            raddr1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            re2    = ($urandom_range(0, 3) != 0);
            raddr2 = ($urandom_range(0, 2) == 0) ? raddr1 : 5'($urandom_range(0, 7));
            whilo  = ($urandom_range(0, 2) == 0);
            hi_i   = $urandom;
            lo_i   = $urandom;
        end

        cyc();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
